// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size codes, FSM states
// and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane extract (loads) and lane merge (sub-word stores).
// Byte offset 0 is bits [31:24]; halfword offset 0 is bits [31:16].
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'h00;
        case (off)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_val = word;
        case (size)
            SZ_BYTE: load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
            SZ_HALF: load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
            default: load_val = word;
        endcase
    end

    // Only the addressed lane(s) are replaced; the rest of the captured word is kept.
    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) merged[15:0]  = wdata[15:0];
                else        merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/halfword/word accesses to a word-wide
// data_memory, using read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              signExt,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic [ADDR_W-3:0] dmAddress,
    output logic [31:0]       dmInData,
    output logic              dmMemRead,
    output logic              dmMemWrite,
    input  logic [31:0]       dmOutData,
    output logic [1:0]        state_dbg
);

    // Handshake: req is sampled only while busy=0; the access is accepted on
    // that edge, busy stays high until done pulses for one cycle, and
    // rdata/misaligned are valid with done and held until the next done.

    logic [1:0]        state;
    logic              a_we;
    logic [1:0]        a_size;
    logic              a_sext;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [31:0]       word_q;
    logic [31:0]       lane_word;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    // During READ the lane logic sees memory directly so the load result is
    // ready at the closing edge; otherwise it works on the captured word.
    assign lane_word = (state == ST_READ) ? dmOutData : word_q;

    lsu_lane u_lane (
        .word     (lane_word),
        .wdata    (a_wdata),
        .size     (a_size),
        .off      (a_addr[1:0]),
        .sign_ext (a_sext),
        .load_val (load_val),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_we       <= 1'b0;
            a_size     <= SZ_BYTE;
            a_sext     <= 1'b0;
            a_addr     <= '0;
            a_wdata    <= '0;
            word_q     <= '0;
            rdata      <= '0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        a_we    <= we;
                        a_size  <= size;
                        a_sext  <= signExt;
                        a_addr  <= addr;
                        a_wdata <= wdata;
                        if (is_misaligned(size, addr[1:0])) begin
                            misaligned <= 1'b1;
                            state      <= ST_DONE;
                        end else if (we && size == SZ_WORD) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    word_q <= dmOutData;
                    if (a_we) begin
                        state <= ST_WRITE;
                    end else begin
                        rdata      <= load_val;
                        misaligned <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    misaligned <= 1'b0;
                    state      <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign dmMemRead  = rst_n && (state == ST_READ);
    assign dmMemWrite = rst_n && (state == ST_WRITE);
    assign dmAddress  = (state == ST_READ || state == ST_WRITE) ? a_addr[ADDR_W-1:2] : '0;
    assign dmInData   = (state == ST_WRITE) ? merged : 32'h0;
    assign state_dbg  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_memory
// (combinational read, write on rising edge).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        signExt;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic [7:0]  dmAddress;
    logic [31:0] dmInData;
    logic        dmMemRead;
    logic        dmMemWrite;
    logic [31:0] dmOutData;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we         (we),
        .size       (size),
        .signExt    (signExt),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .dmAddress  (dmAddress),
        .dmInData   (dmInData),
        .dmMemRead  (dmMemRead),
        .dmMemWrite (dmMemWrite),
        .dmOutData  (dmOutData),
        .state_dbg  (state_dbg)
    );

    assign dmOutData = mem[dmAddress];

    always @(posedge clk) begin
        if (dmMemWrite) mem[dmAddress] <= dmInData;
        if (dmMemRead)  rd_cnt <= rd_cnt + 1;
        if (dmMemWrite) wr_cnt <= wr_cnt + 1;
        if (done)       done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in cycle 1 of the access.
    task automatic issue(input logic w, input logic [1:0] sz, input logic se,
                         input logic [9:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; signExt = se; addr = a; wdata = d;
        tick();
        req = 1'b0;
    endtask

    // Load that must complete at cycle 2 with the given result.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic se,
                           input logic [9:0] a, input logic [31:0] exp);
        issue(1'b0, sz, se, a, 32'h0);
        check({tag, "_rd"}, {31'b0, dmMemRead}, 32'd1);
        tick();
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_rdata"}, rdata, exp);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; signExt = 1'b0;
        addr = '0; wdata = '0;
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_strobes", {30'b0, dmMemRead, dmMemWrite}, 32'd0);
        check("rst_dm_bus", dmInData | {24'b0, dmAddress}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Word store: write at cycle 1, done at cycle 2.
        issue(1'b1, 2'b10, 1'b0, 10'h000, 32'd10);
        check("sw_wr", {31'b0, dmMemWrite}, 32'd1);
        check("sw_addr", {24'b0, dmAddress}, 32'h0);
        check("sw_data", dmInData, 32'h0000000A);
        check("sw_busy", {31'b0, busy}, 32'd1);
        check("sw_nodone", {31'b0, done}, 32'd0);
        tick();
        check("sw_done", {31'b0, done}, 32'd1);
        check("sw_rdata", rdata, 32'h0);
        tick();
        check("sw_idle", {30'b0, busy, done}, 32'd0);
        check("sw_mem", mem[0], 32'h0000000A);
        check("sw_bus_idle", dmInData, 32'h0);

        mem[1] = 32'h8899AABB;
        do_load("lb5", 2'b00, 1'b1, 10'h005, 32'hFFFFFF99);
        do_load("lbu5", 2'b00, 1'b0, 10'h005, 32'h00000099);
        do_load("lh6", 2'b01, 1'b1, 10'h006, 32'hFFFFAABB);
        do_load("lhu4", 2'b01, 1'b0, 10'h004, 32'h00008899);
        do_load("lb7", 2'b00, 1'b1, 10'h007, 32'hFFFFFFBB);
        do_load("lw4", 2'b10, 1'b1, 10'h004, 32'h8899AABB);

        // Byte store: read at cycle 1, merged write at cycle 2, done at cycle 3.
        issue(1'b1, 2'b00, 1'b0, 10'h006, 32'h000000CC);
        check("sb_rd", {31'b0, dmMemRead}, 32'd1);
        check("sb_rd_addr", {24'b0, dmAddress}, 32'h1);
        tick();
        check("sb_wr", {31'b0, dmMemWrite}, 32'd1);
        check("sb_data", dmInData, 32'h8899CCBB);
        check("sb_nodone", {31'b0, done}, 32'd0);
        tick();
        check("sb_done", {31'b0, done}, 32'd1);
        check("sb_rdata_kept", rdata, 32'h8899AABB);
        tick();
        check("sb_mem", mem[1], 32'h8899CCBB);

        issue(1'b1, 2'b01, 1'b0, 10'h000, 32'hFFFF1234);
        tick();
        check("sh_data", dmInData, 32'h1234000A);
        tick(); tick();
        do_load("lw0", 2'b10, 1'b0, 10'h000, 32'h1234000A);

        // Misaligned accesses finish at cycle 1 with no strobes.
        begin
            int rd0, wr0;
            rd0 = rd_cnt; wr0 = wr_cnt;
            issue(1'b0, 2'b01, 1'b1, 10'h003, 32'h0);
            check("mis_lh_done", {31'b0, done}, 32'd1);
            check("mis_lh_flag", {31'b0, misaligned}, 32'd1);
            check("mis_lh_rdata", rdata, 32'h1234000A);
            tick();
            issue(1'b1, 2'b10, 1'b0, 10'h002, 32'h55555555);
            check("mis_sw_flag", {31'b0, misaligned & done}, 32'd1);
            tick();
            issue(1'b0, 2'b11, 1'b0, 10'h004, 32'h0);
            check("mis_rsvd_flag", {31'b0, misaligned & done}, 32'd1);
            tick();
            check("mis_strobes", rd_cnt - rd0 + wr_cnt - wr0, 32'd0);
            check("mis_mem0", mem[0], 32'h1234000A);
        end
        do_load("lb4", 2'b00, 1'b0, 10'h004, 32'h00000088);
        check("mis_cleared", {31'b0, misaligned}, 32'd0);

        // Reset during WRITE must suppress the write.
        issue(1'b1, 2'b10, 1'b0, 10'h004, 32'hDEADBEEF);
        check("rw_in_write", {31'b0, dmMemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_gated", {31'b0, dmMemWrite}, 32'd0);
        tick();
        check("rw_busy", {31'b0, busy}, 32'd0);
        check("rw_done", {31'b0, done}, 32'd0);
        check("rw_rdata", rdata, 32'h0);
        check("rw_mem", mem[1], 32'h8899CCBB);
        rst_n = 1'b1;
        tick();

        // req held high: one access per pass through IDLE.
        begin
            int rd0, dn0;
            rd0 = rd_cnt; dn0 = done_cnt;
            req = 1'b1; we = 1'b0; size = 2'b10; signExt = 1'b0; addr = 10'h004; wdata = '0;
            tick();
            check("hold_c1_rd", {31'b0, dmMemRead}, 32'd1);
            tick();
            check("hold_c2_done", {31'b0, done}, 32'd1);
            tick();
            check("hold_c3_idle", {30'b0, busy, dmMemRead}, 32'd0);
            check("hold_one_rd", rd_cnt - rd0, 32'd1);
            check("hold_one_done", done_cnt - dn0, 32'd1);
            tick();
            req = 1'b0;
            check("hold_c4_rd", {31'b0, dmMemRead}, 32'd1);
            tick();
            check("hold_c5_rdata", rdata & {32{done}}, 32'h8899CCBB);
            tick();
            check("hold_end_idle", {31'b0, busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width; word address = ADDR_W-2 = 8 bits, matching data_memory.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: req  in  1  pipeline access request; sampled only when busy=0.
REQ-005 SHALL have ports: we  in  1  1=store, 0=load.
REQ-006 SHALL have ports: size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have ports: signExt  in  1  sign-extend sub-word loads.
REQ-008 SHALL have ports: addr  in  ADDR_W  byte address.
REQ-009 SHALL have ports: wdata  in  32  store data, right-justified for sub-word stores.
REQ-010 SHALL have ports: busy  out  1 / done  out  1 / rdata  out  32 / misaligned  out  1.
REQ-011 SHALL have ports: dmAddress  out  8 / dmInData  out  32 / dmMemRead  out  1 / dmMemWrite  out  1 / dmOutData  in  32, connected to data_memory.

Function
REQ-012 SHALL implement FSM states IDLE, READ, WRITE, DONE; busy=1 in every state except IDLE.
REQ-013 SHALL, in IDLE with req=1, latch we/size/signExt/addr/wdata and go to: DONE if misaligned; WRITE if word store; READ otherwise.
REQ-014 SHALL flag misaligned when size=01 and addr[0]=1, size=10 and addr[1:0]!=0, or size=11; no dm strobe is asserted for that access.
REQ-015 SHALL in READ drive dmMemRead=1, dmAddress=addr[9:2], capture dmOutData at the closing edge, then go to DONE (load) or WRITE (store).
REQ-016 SHALL in WRITE drive dmMemWrite=1, dmAddress=addr[9:2], dmInData=merged word, then go to DONE.
REQ-017 SHALL use big-endian lanes: byte offset 0 = bits[31:24] ... offset 3 = bits[7:0]; halfword offset 0 = [31:16], 2 = [15:0].
REQ-018 SHALL build sub-word store data by replacing only the addressed lane(s) of the captured word; other lanes unchanged.
REQ-019 SHALL, for loads, extract the addressed lane and zero-extend (signExt=0) or sign-extend (signExt=1) to 32 bits; signExt is ignored for words.
REQ-020 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE; rdata and misaligned are valid with done and held until the next done.
REQ-021 SHALL latency, req edge = cycle 0: misaligned done at cycle 1; load and word store at cycle 2; sub-word store at cycle 3.
REQ-022 SHALL ignore req while busy=1; a req in the DONE cycle is not accepted.
REQ-023 SHALL hold dmMemRead/dmMemWrite at 0 and dmAddress/dmInData at 0 outside READ/WRITE.
REQ-024 SHALL leave rdata unchanged on stores and on misaligned accesses.

Reset
REQ-025 SHALL, on any rising edge with rst_n=0, enter IDLE and clear all latched registers, rdata, misaligned, done, busy.
REQ-026 SHALL gate dmMemWrite and dmMemRead with rst_n so no memory write occurs on a reset edge, including reset during WRITE.

Structure
REQ-027 SHALL place size codes (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding in shared package lsu_pkg.
REQ-028 SHALL implement lane extract/merge in one combinational sub-module lsu_lane, instantiated once.

Verification
REQ-029 SHALL cover: word store addr=0x000, wdata=10 -> cycle 1 dmMemWrite=1, dmAddress=0, dmInData=0x0000000A; done at cycle 2.
REQ-030 SHALL cover: word 1 = 0x8899AABB; lb addr=0x005 signExt=1 -> rdata 0xFFFFFF99; lbu -> 0x00000099; lh addr=0x006 signExt=1 -> 0xFFFFAABB.
REQ-031 SHALL cover: sb addr=0x006 wdata=0x000000CC on 0x8899AABB -> READ then WRITE dmInData=0x8899CCBB; done at cycle 3.
REQ-032 SHALL cover: lh addr=0x003 -> done and misaligned=1 at cycle 1; dmMemRead/dmMemWrite never asserted; rdata unchanged.
REQ-033 SHALL cover: rst_n=0 during WRITE of sw addr=0x004 -> dmMemWrite=0, word 1 unchanged, busy=0 and done=0 after reset.
REQ-034 SHALL cover: req held high across a load -> exactly one access and one done; second request accepted only once back in IDLE.
